// File: rtl/spi_flash_master.sv
// SPI mode-0 master for the configuration flash: one byte per wr_data strobe,
// MSB first, with software-controlled chip select and sticky overrun flag.
module spi_flash_master #(
  parameter int CLKDIV = 2
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       wr_data,
  input  logic       wr_ctrl,
  input  logic       rd_data,
  input  logic [7:0] din,
  output logic [7:0] rx_data,
  output logic [3:0] status,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       csn
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  state_t        state, state_nx;
  logic [DW-1:0] div;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          valid, ovr;
  logic          busy, div_done, complete;

  assign busy     = (state != IDLE);
  assign div_done = (div == DW'(CLKDIV - 1));
  assign complete = (state == HI) && div_done && (bitcnt == 3'd7);
  assign status   = {ovr, ~csn, valid, busy};

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (wr_data)  state_nx = LO;
      LO:      if (div_done) state_nx = HI;
      HI:      if (div_done) state_nx = (bitcnt == 3'd7) ? IDLE : LO;
      default: state_nx = IDLE;
    endcase
  end

  // Shift register doubles as tx and rx: MSB goes out, miso enters at the LSB,
  // so after eight shifts it holds the received byte.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      div     <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      rx_data <= '0;
    end else begin
      case (state)
        IDLE: if (wr_data) begin
          shreg  <= din;
          mosi   <= din[7];
          bitcnt <= '0;
          div    <= '0;
        end
        LO: if (div_done) begin
          div   <= '0;
          sck   <= 1'b1;
          shreg <= {shreg[6:0], miso};
        end else begin
          div <= div + 1'b1;
        end
        HI: if (div_done) begin
          div <= '0;
          sck <= 1'b0;
          if (bitcnt != 3'd7) begin
            mosi   <= shreg[7];
            bitcnt <= bitcnt + 1'b1;
          end else begin
            rx_data <= shreg;
          end
        end else begin
          div <= div + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Completion beats a coincident rd_data so a freshly received byte is never lost.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      valid <= 1'b0;
      ovr   <= 1'b0;
      csn   <= 1'b1;
    end else begin
      if (complete)     valid <= 1'b1;
      else if (rd_data) valid <= 1'b0;

      if (wr_data && busy)        ovr <= 1'b1;
      else if (wr_ctrl && din[7]) ovr <= 1'b0;

      if (wr_ctrl && !busy) csn <= ~din[0];
    end
  end

endmodule

// File: tb/tb_spi_flash_master.sv
// Randomized bench for spi_flash_master: CLKDIV=2 and CLKDIV=1 instances against
// a byte-level flash/host model.
module tb_spi_flash_master;

  logic       clk = 1'b0;
  logic       resetq = 1'b0;
  logic [7:0] din = 8'h00;
  logic       miso;

  logic       wr_data_v [2];
  logic       wr_ctrl_v [2];
  logic       rd_data_v [2];
  logic [7:0] rx_v      [2];
  logic [3:0] st_v      [2];
  logic       sck_v     [2];
  logic       mosi_v    [2];
  logic       csn_v     [2];

  always #5 clk = ~clk;

  spi_flash_master #(.CLKDIV(2)) u_dut2 (
    .clk(clk), .resetq(resetq), .wr_data(wr_data_v[0]), .wr_ctrl(wr_ctrl_v[0]),
    .rd_data(rd_data_v[0]), .din(din), .rx_data(rx_v[0]), .status(st_v[0]),
    .sck(sck_v[0]), .mosi(mosi_v[0]), .miso(miso), .csn(csn_v[0])
  );

  spi_flash_master #(.CLKDIV(1)) u_dut1 (
    .clk(clk), .resetq(resetq), .wr_data(wr_data_v[1]), .wr_ctrl(wr_ctrl_v[1]),
    .rd_data(rd_data_v[1]), .din(din), .rx_data(rx_v[1]), .status(st_v[1]),
    .sck(sck_v[1]), .mosi(mosi_v[1]), .miso(miso), .csn(csn_v[1])
  );

  // Flash model: presents the next bit of flash_byte after every sck fall.
  logic       sel = 1'b0;
  logic [7:0] flash_byte = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  int         fall_cnt = 0, rise_cnt = 0, fall_base = 0, rise_base = 0;
  time        last_rise = 0, rise_gap = 0;
  logic       sck_act, mosi_act;

  assign sck_act  = sel ? sck_v[1]  : sck_v[0];
  assign mosi_act = sel ? mosi_v[1] : mosi_v[0];
  assign miso = (fall_cnt - fall_base < 8) ?
                flash_byte[3'(7 - (fall_cnt - fall_base))] : 1'b0;

  always @(negedge sck_act) fall_cnt++;
  always @(posedge sck_act) begin
    mosi_cap  = {mosi_cap[6:0], mosi_act};
    rise_cnt++;
    rise_gap  = $time - last_rise;
    last_rise = $time;
  end

  int   total = 0, bad = 0;
  logic csn_e [2];
  logic ovr_e [2];
  logic val_e [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] st_exp(input int s, input logic busy);
    return {ovr_e[s], ~csn_e[s], val_e[s], busy};
  endfunction

  task automatic set_ctrl(input int s, input logic [7:0] d);
    @(negedge clk); din = d; wr_ctrl_v[s] = 1'b1;
    @(negedge clk); wr_ctrl_v[s] = 1'b0;
    csn_e[s] = ~d[0];
    if (d[7]) ovr_e[s] = 1'b0;
    chk("ctrl_csn", 32'(csn_v[s]), 32'(csn_e[s]));
    chk("ctrl_status", 32'(st_v[s]), 32'(st_exp(s, 1'b0)));
  endtask

  task automatic rd_pulse(input int s);
    @(negedge clk); rd_data_v[s] = 1'b1;
    @(negedge clk); rd_data_v[s] = 1'b0;
    val_e[s] = 1'b0;
    chk("rd_status", 32'(st_v[s]), 32'(st_exp(s, 1'b0)));
  endtask

  // One byte transfer; strobe pokes are placed at busy cycle numbers (1-based, 0 = none).
  task automatic do_xfer(input int s, input logic [7:0] d, input logic [7:0] fb,
                         input int ovr_at, input int ctl_at, input logic [7:0] ctl_din,
                         input int rd_at);
    int  k, cnt;
    logic setv, clrv;
    k = (s == 0) ? 2 : 1;
    sel = s[0];
    flash_byte = fb;
    fall_base = fall_cnt;
    rise_base = rise_cnt;
    @(negedge clk); din = d; wr_data_v[s] = 1'b1;
    @(negedge clk); wr_data_v[s] = 1'b0;
    cnt = 0;
    while (st_v[s][0] && cnt < 100) begin
      cnt++;
      wr_data_v[s] = (cnt == ovr_at);
      wr_ctrl_v[s] = (cnt == ctl_at);
      rd_data_v[s] = (cnt == rd_at);
      din = (cnt == ctl_at) ? ctl_din : 8'h55;
      @(negedge clk);
    end
    wr_data_v[s] = 1'b0; wr_ctrl_v[s] = 1'b0; rd_data_v[s] = 1'b0;
    setv = (ovr_at >= 1 && ovr_at <= 16 * k);
    clrv = (ctl_at >= 1 && ctl_at <= 16 * k && ctl_din[7]);
    if (setv && clrv) ovr_e[s] = (ovr_at > ctl_at);
    else if (setv)    ovr_e[s] = 1'b1;
    else if (clrv)    ovr_e[s] = 1'b0;
    val_e[s] = 1'b1;
    chk("busy_cycles", 32'(cnt), 32'(16 * k));
    chk("sck_rises", 32'(rise_cnt - rise_base), 32'd8);
    chk("mosi_bits", 32'(mosi_cap), 32'(d));
    chk("sck_period", 32'(rise_gap / 10), 32'(2 * k));
    chk("rx_data", 32'(rx_v[s]), 32'(fb));
    chk("xfer_status", 32'(st_v[s]), 32'(st_exp(s, 1'b0)));
    chk("xfer_csn", 32'(csn_v[s]), 32'(csn_e[s]));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      wr_data_v[i] = 1'b0; wr_ctrl_v[i] = 1'b0; rd_data_v[i] = 1'b0;
      csn_e[i] = 1'b1; ovr_e[i] = 1'b0; val_e[i] = 1'b0;
    end

    // Reset state
    #12;
    chk("rst_csn", 32'(csn_v[0]), 32'd1);
    chk("rst_sck", 32'(sck_v[0]), 32'd0);
    chk("rst_mosi", 32'(mosi_v[0]), 32'd0);
    chk("rst_status", 32'(st_v[0]), 32'h0);
    chk("rst_rx", 32'(rx_v[0]), 32'h00);
    chk("rst_status1", 32'(st_v[1]), 32'h0);
    @(negedge clk); resetq = 1'b1;

    // Basic 9F command with A5 reply
    set_ctrl(0, 8'h01);
    do_xfer(0, 8'h9F, 8'hA5, 0, 0, 8'h00, 0);
    chk("basic_status", 32'(st_v[0]), 32'b0110);

    // Overrun during bit 3, then clear with CS kept asserted
    do_xfer(0, 8'h3C, 8'h5A, 13, 0, 8'h00, 0);
    chk("ovr_set", 32'(st_v[0][3]), 32'd1);
    set_ctrl(0, 8'h81);
    chk("ovr_clr", 32'(st_v[0][3]), 32'd0);

    // rd_data coincident with completion, then alone
    do_xfer(0, 8'hC6, 8'h81, 0, 0, 8'h00, 32);
    chk("rd_vs_done", 32'(st_v[0][1]), 32'd1);
    rd_pulse(0);

    // Async reset during bit 4
    sel = 1'b0; fall_base = fall_cnt; rise_base = rise_cnt; flash_byte = 8'h77;
    @(negedge clk); din = 8'hC3; wr_data_v[0] = 1'b1;
    @(negedge clk); wr_data_v[0] = 1'b0;
    n = 0;
    while (rise_cnt - rise_base < 5 && n < 200) begin n++; @(negedge clk); end
    chk("rst_wait", 32'(n < 200), 32'd1);
    #2 resetq = 1'b0;
    #1;
    chk("arst_sck", 32'(sck_v[0]), 32'd0);
    chk("arst_csn", 32'(csn_v[0]), 32'd1);
    chk("arst_status", 32'(st_v[0]), 32'h0);
    chk("arst_rx", 32'(rx_v[0]), 32'h00);
    for (int i = 0; i < 2; i++) begin csn_e[i] = 1'b1; ovr_e[i] = 1'b0; val_e[i] = 1'b0; end
    @(negedge clk); resetq = 1'b1;
    set_ctrl(0, 8'h01);
    do_xfer(0, 8'h03, 8'($urandom), 0, 0, 8'h00, 0);

    // CLKDIV=1 instance: CS change while busy is ignored
    set_ctrl(1, 8'h01);
    do_xfer(1, 8'hFF, 8'($urandom), 0, 5, 8'h00, 0);
    chk("cs_busy_ign", 32'(csn_v[1]), 32'd0);

    // Randomized transfers on both instances
    for (int it = 0; it < 14; it++) begin
      int s, k, oa, ca, ra;
      s  = int'($urandom_range(0, 1));
      k  = (s == 0) ? 2 : 1;
      if ($urandom_range(0, 3) == 0) set_ctrl(s, 8'($urandom));
      oa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16 * k)) : 0;
      ca = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16 * k)) : 0;
      if (ca == oa) ca = 0;
      ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16 * k)) : 0;
      do_xfer(s, 8'($urandom), 8'($urandom), oa, ca, 8'($urandom), ra);
      if ($urandom_range(0, 1) == 1) rd_pulse(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
